// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester writeback arbiter feeding a single
// register-file write port through a one-entry output stage.
// Optional feature macro: REGFILE_WB_RR_EN selects round-robin arbitration
// (undefined: requester 0 has fixed priority).
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [3:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        rf_hold,
    output logic [3:0]  wr,
    output logic [31:0] writeData,
    output logic        regWrite,
    output logic [15:0] pend_mask,
    output logic [7:0]  wb_count
);

    logic        full_q;
    logic [3:0]  wr_q;
    logic [31:0] data_q;
    logic [7:0]  cnt_q;
    logic        free;
    logic        gnt1;
    logic        accept;
    logic        retire;

`ifdef REGFILE_WB_RR_EN
    // 1 when requester 1 won the most recent accepted arbitration
    logic        last_q;
`endif

    // Output stage can take a new entry when empty or when its write retires now
    assign free   = !full_q || !rf_hold;
    assign retire = full_q && !rf_hold && !reset;

    // Grant selection; a lone requester always wins
    always_comb begin
        gnt1 = 1'b0;
        if (req1_valid && !req0_valid) begin
            gnt1 = 1'b1;
        end else if (req1_valid && req0_valid) begin
`ifdef REGFILE_WB_RR_EN
            gnt1 = !last_q;
`else
            gnt1 = 1'b0;
`endif
        end
    end

    assign req0_ready = !reset && free && req0_valid && !gnt1;
    assign req1_ready = !reset && free && req1_valid && gnt1;
    assign accept     = req0_ready || req1_ready;

    assign wr        = wr_q;
    assign writeData = data_q;
    assign regWrite  = retire;
    assign pend_mask = full_q ? (16'd1 << wr_q) : 16'd0;
    assign wb_count  = cnt_q;

    // Output stage: load on acceptance, empty on retirement, discard on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            wr_q   <= 4'd0;
            data_q <= 32'd0;
        end else if (accept) begin
            full_q <= 1'b1;
            wr_q   <= gnt1 ? req1_addr : req0_addr;
            data_q <= gnt1 ? req1_data : req0_data;
        end else if (retire) begin
            full_q <= 1'b0;
        end
    end

    // Completed-write counter, wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (retire) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

`ifdef REGFILE_WB_RR_EN
    // Last-grant tracking moves only when a request is actually accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt1;
        end
    end
`endif

endmodule
